// File: rtl/uart_rx_ext_if.sv
// Serial-side and word-side signals of uart_rx_ext.
// The receiver takes the slave modport; the line driver / RX FIFO side takes the master modport.
interface uart_rx_ext_if #(
    parameter int NB_DATA = 8
);
    logic               i_s_tick;
    logic               i_rx;
    logic [NB_DATA-1:0] o_rx_data;
    logic               o_rx_done_tick;
    logic               o_parity_err;
    logic               o_frame_err;
    logic               o_break;
    logic               o_busy;

    modport slave (
        input  i_s_tick, i_rx,
        output o_rx_data, o_rx_done_tick, o_parity_err, o_frame_err, o_break, o_busy
    );

    modport master (
        output i_s_tick, i_rx,
        input  o_rx_data, o_rx_done_tick, o_parity_err, o_frame_err, o_break, o_busy
    );
endinterface

// File: rtl/uart_rx_ext.sv
// Oversampling UART receiver: majority-voted bits, LSB-first frames, framing/break/parity flags.
// Define UART_RX_PARITY_EN to expect one parity bit (odd or even per PARITY_ODD) after the data bits.
module uart_rx_ext #(
    parameter int NB_DATA    = 8,
    parameter int OVERSAMPLE = 16,
    parameter int NB_STOP    = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    uart_rx_ext_if.slave  bus
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = $clog2(NB_DATA);
    localparam logic [CW-1:0] C_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] C_S0   = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] C_S1   = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] C_DEC  = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [IW-1:0] IDX_DATA_LAST = IW'(NB_DATA - 1);
    localparam logic [IW-1:0] IDX_STOP_LAST = IW'(NB_STOP - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
    localparam logic PAR_ODD = (PARITY_ODD != 0);
    logic par_q, par_d;
    logic perr_q, perr_d;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;
    logic unused_parity_cfg;
    assign unused_parity_cfg = (PARITY_ODD != 0);
`endif

    state_t             state_q, state_d;
    logic               rx_meta_q, rx_s_q, rx_d_q;
    logic [CW-1:0]      c_q, c_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [1:0]         smp_q, smp_d;
    logic [NB_DATA-1:0] shreg_q, shreg_d;
    logic               ferr_q, ferr_d;
    logic               any_one_q, any_one_d;
    logic [NB_DATA-1:0] data_q, data_d;
    logic               done_q, done_d;
    logic               frame_err_q, frame_err_d;
    logic               break_q, break_d;
    logic               bit_val, dec_tick, last_tick;

    always_comb begin
        state_d     = state_q;
        c_d         = c_q;
        idx_d       = idx_q;
        smp_d       = smp_q;
        shreg_d     = shreg_q;
        ferr_d      = ferr_q;
        any_one_d   = any_one_q;
        data_d      = data_q;
        done_d      = 1'b0;
        frame_err_d = frame_err_q;
        break_d     = break_q;
`ifdef UART_RX_PARITY_EN
        par_d       = par_q;
        perr_d      = perr_q;
`endif
        // Third sample is the live synchronised line on the decision tick.
        bit_val   = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s_q) | (smp_q[1] & rx_s_q);
        dec_tick  = bus.i_s_tick && (c_q == C_DEC);
        last_tick = bus.i_s_tick && (c_q == C_LAST);

        if (state_q != ST_IDLE && bus.i_s_tick) begin
            c_d = last_tick ? '0 : c_q + 1'b1;
            if (c_q == C_S0) smp_d[0] = rx_s_q;
            if (c_q == C_S1) smp_d[1] = rx_s_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (!rx_s_q && rx_d_q) begin
                    state_d   = ST_START;
                    c_d       = '0;
                    idx_d     = '0;
                    ferr_d    = 1'b0;
                    any_one_d = 1'b0;
`ifdef UART_RX_PARITY_EN
                    par_d     = 1'b0;
`endif
                end
            end
            ST_START: begin
                if (dec_tick && bit_val) begin
                    state_d = ST_IDLE;
                    c_d     = '0;
                end else if (last_tick) begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                end
            end
            ST_DATA: begin
                if (dec_tick) begin
                    shreg_d[idx_q] = bit_val;
                    any_one_d      = any_one_q | bit_val;
`ifdef UART_RX_PARITY_EN
                    par_d          = par_q ^ bit_val;
`endif
                end
                if (last_tick) begin
                    if (idx_q == IDX_DATA_LAST) begin
                        idx_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (dec_tick) begin
                    par_d     = par_q ^ bit_val;
                    any_one_d = any_one_q | bit_val;
                end
                if (last_tick) begin
                    state_d = ST_STOP;
                    idx_d   = '0;
                end
            end
`endif
            ST_STOP: begin
                if (dec_tick) begin
                    ferr_d    = ferr_q | ~bit_val;
                    any_one_d = any_one_q | bit_val;
                    // Leave half a bit early so the next start edge is never missed.
                    if (idx_q == IDX_STOP_LAST) begin
                        state_d     = ST_IDLE;
                        c_d         = '0;
                        done_d      = 1'b1;
                        data_d      = shreg_q;
                        frame_err_d = ferr_q | ~bit_val;
                        break_d     = ~(any_one_q | bit_val);
`ifdef UART_RX_PARITY_EN
                        perr_d      = par_q ^ PAR_ODD;
`endif
                    end
                end
                if (last_tick) idx_d = idx_q + 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                c_d     = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_d_q      <= 1'b1;
            state_q     <= ST_IDLE;
            c_q         <= '0;
            idx_q       <= '0;
            smp_q       <= '0;
            shreg_q     <= '0;
            ferr_q      <= 1'b0;
            any_one_q   <= 1'b0;
            data_q      <= '0;
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;
            break_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q       <= 1'b0;
            perr_q      <= 1'b0;
`endif
        end else begin
            rx_meta_q   <= bus.i_rx;
            rx_s_q      <= rx_meta_q;
            rx_d_q      <= rx_s_q;
            state_q     <= state_d;
            c_q         <= c_d;
            idx_q       <= idx_d;
            smp_q       <= smp_d;
            shreg_q     <= shreg_d;
            ferr_q      <= ferr_d;
            any_one_q   <= any_one_d;
            data_q      <= data_d;
            done_q      <= done_d;
            frame_err_q <= frame_err_d;
            break_q     <= break_d;
`ifdef UART_RX_PARITY_EN
            par_q       <= par_d;
            perr_q      <= perr_d;
`endif
        end
    end

    assign bus.o_rx_data      = data_q;
    assign bus.o_rx_done_tick = done_q;
    assign bus.o_frame_err    = frame_err_q;
    assign bus.o_break        = break_q;
    assign bus.o_busy         = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
    assign bus.o_parity_err   = perr_q;
`else
    assign bus.o_parity_err   = 1'b0;
`endif
endmodule

// File: doc/uart_rx_ext.md
# uart_rx_ext

Parametrised UART receiver, successor to the fixed 8-bit receiver. It oversamples the serial line on the shared baud-tick strobe and assembles LSB-first frames of configurable data width, oversampling ratio and stop-bit count. It resolves each bit by majority vote and reports framing, break and (optionally) parity errors alongside each received word. It sits between the pad-side `i_rx` line and the RX FIFO / interface logic, driven by the same baud generator as the transmitter.

## Interface
- `NB_DATA`, 8: data bits per frame, legal 5..9.
- `OVERSAMPLE`, 16: `i_s_tick` pulses per bit, even, legal 8..32.
- `NB_STOP`, 1: stop bits expected, legal 1 or 2.
- `PARITY_ODD`, 0: 1 = odd parity, 0 = even. Only meaningful with `UART_RX_PARITY_EN`.
- `i_clk`  in  1  system clock. One clock domain; all logic is rising-edge.
- `i_reset_n`  in  1  reset, asynchronous assert, active-low.
- `i_s_tick`  in  1  baud oversample strobe, one `i_clk` cycle wide.
- `i_rx`  in  1  serial line, asynchronous, idle high.
- `o_rx_data`  out  `NB_DATA`  last received word, LSB = first data bit.
- `o_rx_done_tick`  out  1  one-cycle pulse, frame complete.
- `o_parity_err`  out  1  parity mismatch on last frame.
- `o_frame_err`  out  1  any stop bit sampled 0 on last frame.
- `o_break`  out  1  last frame was all-zero including the stop bits.
- `o_busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- **Input synchroniser:** `i_rx` passes through 2 flops, both resetting to 1, giving `rx_s`. One more flop, `rx_d`, provides edge detection.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - PARITY exists only with the macro defined.
- **Tick counter** `c` has width clog2(`OVERSAMPLE`). It increments on each `i_s_tick`, resets to 0 on every state or bit change, and wraps at `OVERSAMPLE`-1.
- **Bit sampling:** `rx_s` is captured on ticks where `c` = M-1, M and M+1, with M = `OVERSAMPLE`/2. The bit value is the majority of the 3 samples, decided on the tick where `c` = M+1.
- **IDLE:** on `rx_s`=0 with `rx_d`=1 (falling edge), go to START with `c`=0.
  - A constantly-low line does not start a frame.
- **START:** at the decision tick:
  - If the majority is 1, this is a false start: return to IDLE with no done pulse.
  - Otherwise finish the bit. On the tick with `c`=`OVERSAMPLE`-1, go to DATA with bit index 0.
- **DATA:** each decided bit shifts into bit position `index` of the shift register (LSB first). After bit `NB_DATA`-1 completes, go to PARITY, or to STOP if the macro is not defined.
- **PARITY:** one bit is decided. Error = (XOR of data bits XOR parity bit) != `PARITY_ODD`.
- **STOP:** `NB_STOP` bits are decided. Any stop bit decided 0 sets the frame error.
  - At the decision tick of the last stop bit, return to IDLE immediately, half a bit early, to allow resynchronisation.
- **Frame completion:** in the cycle after the last stop decision:
  - `o_rx_done_tick` = 1.
  - `o_rx_data`, `o_parity_err`, `o_frame_err` and `o_break` load together.
  - All four hold until the next done pulse.
- **Break:** `o_break`=1 when all data bits, the parity bit (if present) and all stop bits decided 0. A break always also sets `o_frame_err`=1.
  - After a break, no new frame starts until `rx_s` returns high and then falls again.
- **Reset:** asynchronous, valid at any time including mid-frame.
  - FSM goes to IDLE; counters and the shift register clear; synchroniser flops go to 1.
  - All outputs go to 0, with `o_busy`=0.
  - A partial frame is discarded with no done pulse.

## Timing
- Input latency: 2 `i_clk` cycles from `i_rx` to `rx_s`.
- Frame latency: `o_rx_done_tick` occurs F·`OVERSAMPLE` + M + 2 ticks after the falling edge, plus 1 `i_clk`.
  - F = 1 + `NB_DATA` + P + (`NB_STOP`-1), with P = 1 if the macro is defined, else 0.
- `o_rx_done_tick` is exactly 1 cycle wide and never asserts on consecutive cycles.
- A new start edge is accepted from the first `i_clk` cycle after the return to IDLE.
- Simultaneous reset and tick: reset wins.
- `i_s_tick` has no effect while in IDLE other than edge arming.

## Configuration
- **Macro `UART_RX_PARITY_EN`:**
  - **Defined:** the PARITY state is present; one parity bit follows the data bits; `o_parity_err` is computed per `PARITY_ODD`.
  - **Undefined:** no parity bit is expected; the stop bit immediately follows the data bits; `o_parity_err` is tied to 0; `PARITY_ODD` is ignored.

## Test plan
- **Default 8N1 frame:** default params, send 0xAA → `o_rx_data`=8'hAA, one-cycle done pulse, all error flags 0, `o_busy` back to 0.
- **False start:** `i_rx` low for 4 ticks, then high → no done pulse, FSM returns to IDLE. A following 0x3C frame is received as 0x3C.
- **Framing error:** 0x3C sent with stop bit 0 → done, `o_rx_data`=8'h3C, `o_frame_err`=1, `o_break`=0.
- **Break:** line held low for 12 bit times → exactly one done with `o_break`=1, `o_frame_err`=1, data 0. The next done comes only after the line rises and a 0x5A frame is sent.
- **Parity (macro defined, `PARITY_ODD`=0, `NB_DATA`=7):**
  - 0x07 with parity bit 1 → `o_parity_err`=0.
  - Same frame with parity bit 0 → `o_parity_err`=1.
- **Glitch and reset:**
  - A 1-tick glitch at centre of data bit 2 still yields the correct byte.
  - `i_reset_n` pulsed low during data bit 3 → all outputs 0 asynchronously. A following 0x5A frame is received correctly.
